// File: rtl/nonce_search_ctrl.sv
// Mining-loop sequencer: walks a nonce range through the SHA-256 core and stops on the first comparator hit.
// Optional continuous mode (NONCE_SEARCH_CONT_EN): hits are recorded and the scan runs to the end of the range.
module nonce_search_ctrl #(
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  output logic               hash_req,
  input  logic               hash_ack,
  output logic [NONCE_W-1:0] hash_nonce,
  input  logic               hash_done,
  input  logic               cmp_hit,
  output logic               busy,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               exhausted,
`ifdef NONCE_SEARCH_CONT_EN
  output logic [CNT_W-1:0]   hit_count,
`endif
  output logic [CNT_W-1:0]   hash_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT      = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_FOUND     = 3'd4;
  localparam logic [2:0] S_EXHAUSTED = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [NONCE_W-1:0] cur_q, cur_d;
  logic [NONCE_W-1:0] end_q, end_d;
  logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
  logic               found_q, found_d;
  logic               exhausted_q, exhausted_d;
  logic [CNT_W-1:0]   hash_count_q, hash_count_d;
`ifdef NONCE_SEARCH_CONT_EN
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    end_d         = end_q;
    found_nonce_d = found_nonce_q;
`ifdef NONCE_SEARCH_CONT_EN
    found_d       = 1'b0;
    hit_count_d   = hit_count_q;
`else
    found_d       = found_q;
`endif
    exhausted_d   = exhausted_q;
    hash_count_d  = hash_count_q;

    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        // stop in the same cycle drops the start
        if (start && !stop) begin
          cur_d        = nonce_start;
          end_d        = nonce_end;
          found_d      = 1'b0;
          exhausted_d  = 1'b0;
          hash_count_d = '0;
`ifdef NONCE_SEARCH_CONT_EN
          hit_count_d  = '0;
`endif
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stop && hash_ack)  state_d = S_DRAIN;
        else if (stop)         state_d = S_IDLE;
        else if (hash_ack)     state_d = S_WAIT;
      end
      S_WAIT: begin
        // a stop coinciding with done discards that result; nothing is left to drain
        if (stop) begin
          state_d = hash_done ? S_IDLE : S_DRAIN;
        end else if (hash_done) begin
          hash_count_d = sat_inc(hash_count_q);
          if (cmp_hit) begin
            found_nonce_d = cur_q;
            found_d       = 1'b1;
`ifdef NONCE_SEARCH_CONT_EN
            hit_count_d   = sat_inc(hit_count_q);
`endif
          end
`ifdef NONCE_SEARCH_CONT_EN
          if (cur_q == end_q) begin
`else
          if (cmp_hit) begin
            state_d = S_FOUND;
          end else if (cur_q == end_q) begin
`endif
            exhausted_d = 1'b1;
            state_d     = S_EXHAUSTED;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (hash_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      end_q         <= '0;
      found_nonce_q <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      hash_count_q  <= '0;
`ifdef NONCE_SEARCH_CONT_EN
      hit_count_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      end_q         <= end_d;
      found_nonce_q <= found_nonce_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      hash_count_q  <= hash_count_d;
`ifdef NONCE_SEARCH_CONT_EN
      hit_count_q   <= hit_count_d;
`endif
    end
  end

  assign hash_req    = (state_q == S_ISSUE);
  assign hash_nonce  = cur_q;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign exhausted   = exhausted_q;
  assign hash_count  = hash_count_q;
`ifdef NONCE_SEARCH_CONT_EN
  assign hit_count   = hit_count_q;
`endif

endmodule
